// File: rtl/sd_spi_responder_if.sv
`default_nettype none
// sd_spi_responder_if: SPI pin bundle between the SD controller (master) and card model (slave).
interface sd_spi_responder_if;
   logic SCK;
   logic SS;
   logic MOSI;
   logic MISO;

   modport master (output SCK, output SS, output MOSI, input MISO);
   modport slave  (input SCK, input SS, input MOSI, output MISO);
endinterface
`default_nettype wire

// File: rtl/sd_spi_responder.sv
`default_nettype none
// sd_spi_responder: SPI-mode microSD card model with CMD0/8/55/ACMD41/58/17/24 and a word memory.
// Define SD_RESP_CRC_CHECK_EN to check CRC7 on CMD0 and CMD8.
module sd_spi_responder #(
   parameter int MEM_DEPTH    = 256,
   parameter int NCR_BYTES    = 1,
   parameter int NAC_BYTES    = 1,
   parameter int BUSY_BYTES   = 2,
   parameter int INIT_RETRIES = 2
) (
   input  logic                         control_clk_i,
   input  logic                         control_rst_i,
   sd_spi_responder_if.slave            spi,
   input  logic                         preload_we_i,
   input  logic [$clog2(MEM_DEPTH)-1:0] preload_addr_i,
   input  logic [31:0]                  preload_data_i,
   output logic                         card_idle_o,
   output logic                         cmd_strobe_o,
   output logic [5:0]                   cmd_index_o,
   output logic                         mem_wr_o
);

   localparam int AW        = $clog2(MEM_DEPTH);
   localparam int CW        = 16;
   localparam int NCR_BITS  = NCR_BYTES * 8;
   localparam int NAC_BITS  = NAC_BYTES * 8;
   localparam int BUSY_BITS = BUSY_BYTES * 8;
   localparam int RD_BITS   = 56;
   localparam int WR_BITS   = 48;

   typedef enum logic [3:0] {
      S_HUNT     = 4'd0,
      S_CMD_RX   = 4'd1,
      S_NCR      = 4'd2,
      S_RESP     = 4'd3,
      S_RD_NAC   = 4'd4,
      S_RD_DATA  = 4'd5,
      S_WR_TOKEN = 4'd6,
      S_WR_DATA  = 4'd7,
      S_WR_RESP  = 4'd8,
      S_WR_BUSY  = 4'd9
   } state_t;

   logic [2:0]    r_sck_sr, r_ss_sr, r_mosi_sr;
   logic          r_sck_sync, r_sck_d, r_ss_sync, r_mosi_sync;
   state_t        r_state, w_state_nxt, r_after, w_after;
   logic [CW-1:0] r_cnt, r_resp_len, w_resp_len;
   logic [46:0]   r_shift;
   logic [55:0]   r_tx, w_resp;
   logic [31:0]   r_wdata;
   logic [AW-1:0] r_addr;
   logic          r_miso, r_idle, r_app, r_strobe, r_mem_wr;
   logic [7:0]    r_acmd_cnt, w_acmd_nxt;
   logic [5:0]    r_index;
   logic          w_idle_nxt, w_app_nxt;
   logic [31:0]   r_mem [MEM_DEPTH];

   logic          w_sck_rise, w_sck_fall, w_cnt_ev, w_frame_done, w_commit;
   logic          w_in_range, w_crc_bad;
   logic [47:0]   w_frame;
   logic [5:0]    w_idx;
   logic [31:0]   w_arg;
   logic [7:0]    w_i;
   logic          w_unused;

   // Two-flop synchronizers; the third stage of SCK is the edge-detect delay.
   always_ff @(posedge control_clk_i or posedge control_rst_i) begin
      if (control_rst_i) begin
         r_sck_sr  <= 3'b111;
         r_ss_sr   <= 3'b111;
         r_mosi_sr <= 3'b111;
      end else begin
         r_sck_sr  <= {r_sck_sr[1:0], spi.SCK};
         r_ss_sr   <= {r_ss_sr[1:0], spi.SS};
         r_mosi_sr <= {r_mosi_sr[1:0], spi.MOSI};
      end
   end

   assign r_sck_sync  = r_sck_sr[1];
   assign r_sck_d     = r_sck_sr[2];
   assign r_ss_sync   = r_ss_sr[1];
   assign r_mosi_sync = r_mosi_sr[1];
   assign w_sck_rise  = r_sck_sync & ~r_sck_d;
   assign w_sck_fall  = ~r_sck_sync & r_sck_d;
   assign w_frame     = {r_shift, r_mosi_sync};
   assign w_idx       = w_frame[45:40];
   assign w_arg       = w_frame[39:8];
   assign w_i         = {7'd0, r_idle};
   assign w_in_range  = (w_arg < 32'(MEM_DEPTH));
   assign w_unused    = ^{w_frame[7:0], r_sck_sr[0], r_ss_sr[2:0], r_mosi_sr[2]};

`ifdef SD_RESP_CRC_CHECK_EN
   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = 7'd0;
      for (int k = 39; k >= 0; k--) begin
         fb = d[k] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   assign w_crc_bad = ((w_idx == 6'd0) || (w_idx == 6'd8)) && (crc7(w_frame[47:8]) != w_frame[7:1]);
`else
   assign w_crc_bad = 1'b0;
`endif

   // Command decode: response bytes left-aligned in 56 bits, padded with 1s.
   always_comb begin
      w_resp     = {8'h04 | w_i, {48{1'b1}}};
      w_resp_len = CW'(8);
      w_after    = S_HUNT;
      w_idle_nxt = r_idle;
      w_acmd_nxt = r_acmd_cnt;
      w_app_nxt  = 1'b0;
      if (w_crc_bad) begin
         w_resp = {8'h08 | w_i, {48{1'b1}}};
      end else begin
         case (w_idx)
            6'd0: begin
               w_resp     = {8'h01, {48{1'b1}}};
               w_idle_nxt = 1'b1;
               w_acmd_nxt = 8'd0;
            end
            6'd8: begin
               w_resp     = {w_i, 8'h00, 8'h00, 8'h01, w_arg[7:0], 16'hFFFF};
               w_resp_len = CW'(40);
            end
            6'd55: begin
               w_resp    = {w_i, {48{1'b1}}};
               w_app_nxt = 1'b1;
            end
            6'd41: begin
               if (r_app) begin
                  if (r_acmd_cnt < 8'(INIT_RETRIES)) begin
                     w_resp     = {8'h01, {48{1'b1}}};
                     w_acmd_nxt = r_acmd_cnt + 8'd1;
                  end else begin
                     w_resp     = {8'h00, {48{1'b1}}};
                     w_idle_nxt = 1'b0;
                  end
               end
            end
            6'd58: begin
               w_resp     = {w_i, 32'hC0FF_8000, 16'hFFFF};
               w_resp_len = CW'(40);
            end
            6'd17, 6'd24: begin
               if (r_idle) begin
                  w_resp = {8'h05, {48{1'b1}}};
               end else if (!w_in_range) begin
                  w_resp = {8'h40, {48{1'b1}}};
               end else begin
                  w_resp  = {8'h00, {48{1'b1}}};
                  w_after = (w_idx == 6'd17) ? S_RD_NAC : S_WR_TOKEN;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge control_clk_i or posedge control_rst_i) begin
      if (control_rst_i) r_state <= S_HUNT;
      else               r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_ev     = 1'b0;
      w_frame_done = 1'b0;
      w_commit     = 1'b0;
      if (r_ss_sync) begin
         w_state_nxt = S_HUNT;
      end else begin
         case (r_state)
            S_HUNT: if (w_sck_rise && !r_mosi_sync) w_state_nxt = S_CMD_RX;
            S_CMD_RX: begin
               w_cnt_ev = w_sck_rise;
               if (w_sck_rise && r_cnt == CW'(46)) begin
                  w_frame_done = w_frame[46];
                  w_state_nxt  = w_frame[46] ? S_NCR : S_HUNT;
               end
            end
            S_NCR: begin
               w_cnt_ev = w_sck_fall;
               if (w_sck_fall && r_cnt == CW'(NCR_BITS - 1)) w_state_nxt = S_RESP;
            end
            S_RESP: begin
               w_cnt_ev = w_sck_fall;
               if (w_sck_fall && r_cnt == r_resp_len - CW'(1)) w_state_nxt = r_after;
            end
            S_RD_NAC: begin
               w_cnt_ev = w_sck_fall;
               if (w_sck_fall && r_cnt == CW'(NAC_BITS - 1)) w_state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
               w_cnt_ev = w_sck_fall;
               if (w_sck_fall && r_cnt == CW'(RD_BITS - 1)) w_state_nxt = S_HUNT;
            end
            S_WR_TOKEN: if (w_sck_rise && !r_mosi_sync) w_state_nxt = S_WR_DATA;
            S_WR_DATA: begin
               w_cnt_ev = w_sck_rise;
               if (w_sck_rise && r_cnt == CW'(WR_BITS - 1)) w_state_nxt = S_WR_RESP;
            end
            S_WR_RESP: begin
               w_cnt_ev = w_sck_fall;
               w_commit = w_sck_fall && (r_cnt == CW'(0));
               if (w_sck_fall && r_cnt == CW'(7)) w_state_nxt = S_WR_BUSY;
            end
            S_WR_BUSY: begin
               w_cnt_ev = w_sck_fall;
               if (w_sck_fall && r_cnt == CW'(BUSY_BITS - 1)) w_state_nxt = S_HUNT;
            end
            default: w_state_nxt = S_HUNT;
         endcase
      end
   end

   always_ff @(posedge control_clk_i or posedge control_rst_i) begin
      if (control_rst_i) begin
         r_cnt      <= '0;
         r_shift    <= '0;
         r_tx       <= '1;
         r_resp_len <= CW'(8);
         r_after    <= S_HUNT;
         r_wdata    <= '0;
         r_addr     <= '0;
         r_miso     <= 1'b1;
         r_idle     <= 1'b1;
         r_app      <= 1'b0;
         r_acmd_cnt <= 8'd0;
         r_strobe   <= 1'b0;
         r_index    <= 6'd0;
         r_mem_wr   <= 1'b0;
      end else begin
         r_strobe <= w_frame_done;
         r_mem_wr <= w_commit;
         if (r_ss_sync || (w_state_nxt != r_state)) r_cnt <= '0;
         else if (w_cnt_ev)                         r_cnt <= r_cnt + CW'(1);
         if (w_sck_rise && !r_ss_sync) r_shift <= w_frame[46:0];
         if (r_ss_sync) begin
            r_miso <= 1'b1;
         end else if (w_sck_fall) begin
            case (r_state)
               S_RESP, S_RD_DATA, S_WR_RESP: begin
                  r_miso <= r_tx[55];
                  r_tx   <= {r_tx[54:0], 1'b1};
               end
               S_WR_BUSY: r_miso <= 1'b0;
               default:   r_miso <= 1'b1;
            endcase
         end
         if (w_frame_done) begin
            r_tx       <= w_resp;
            r_resp_len <= w_resp_len;
            r_after    <= w_after;
            r_idle     <= w_idle_nxt;
            r_acmd_cnt <= w_acmd_nxt;
            r_app      <= w_app_nxt;
            r_index    <= w_idx;
            r_addr     <= w_arg[AW-1:0];
         end
         if (r_state == S_RD_NAC && w_state_nxt == S_RD_DATA)
            r_tx <= {8'hFE, r_mem[r_addr], 16'hFFFF};
         if (r_state == S_WR_DATA && w_state_nxt == S_WR_RESP) begin
            r_tx    <= {8'h05, {48{1'b1}}};
            r_wdata <= w_frame[47:16];
         end
      end
   end

   // Memory survives reset; backdoor preload wins over a same-address commit.
   always_ff @(posedge control_clk_i) begin
      if (w_commit && !(preload_we_i && preload_addr_i == r_addr))
         r_mem[r_addr] <= r_wdata;
      if (preload_we_i)
         r_mem[preload_addr_i] <= preload_data_i;
   end

   assign spi.MISO     = r_miso;
   assign card_idle_o  = r_idle;
   assign cmd_strobe_o = r_strobe;
   assign cmd_index_o  = r_index;
   assign mem_wr_o     = r_mem_wr;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_responder.sv
`default_nettype none
// Directed bench for sd_spi_responder: byte-wise SPI master with an expected-MISO-byte scoreboard.
module tb_sd_spi_responder;
   localparam int HALF = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        pre_we;
   logic [7:0]  pre_addr;
   logic [31:0] pre_data;
   logic        card_idle, cmd_strobe, mem_wr;
   logic [5:0]  cmd_index;
   int          vectors = 0;
   int          miscompares = 0;
   int          wr_pulses = 0;
   int          strobes = 0;
   int          sent_cmds = 0;
   int          wr_base;
   logic [7:0]  exp_q[$];
   logic [7:0]  rx_dummy;

   sd_spi_responder_if spi_if();

   sd_spi_responder dut (
      .control_clk_i (clk),
      .control_rst_i (rst),
      .spi           (spi_if),
      .preload_we_i  (pre_we),
      .preload_addr_i(pre_addr),
      .preload_data_i(pre_data),
      .card_idle_o   (card_idle),
      .cmd_strobe_o  (cmd_strobe),
      .cmd_index_o   (cmd_index),
      .mem_wr_o      (mem_wr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wr === 1'b1)     wr_pulses++;
      if (cmd_strobe === 1'b1) strobes++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int b = 7; b >= 0; b--) begin
         spi_if.SCK  = 1'b0;
         spi_if.MOSI = tx[b];
         repeat (HALF) @(negedge clk);
         rx[b]      = spi_if.MISO;
         spi_if.SCK = 1'b1;
         repeat (HALF) @(negedge clk);
      end
   endtask

   task automatic want(input logic [7:0] e);
      exp_q.push_back(e);
   endtask

   task automatic xfer(input logic [7:0] tx);
      logic [7:0] rx, e;
      spi_byte(tx, rx);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      check("miso_byte", {24'd0, rx}, {24'd0, e});
   endtask

   task automatic rd(input int n);
      for (int k = 0; k < n; k++) xfer(8'hFF);
   endtask

   task automatic send_cmd(input logic [47:0] f);
      for (int k = 0; k < 7; k++) want(8'hFF);
      for (int k = 0; k < 6; k++) xfer(f[47-8*k -: 8]);
      xfer(8'hFF);
      sent_cmds++;
   endtask

   task automatic init_card();
      for (int k = 0; k < 3; k++) begin
         send_cmd(48'h770000000001); want(8'h01); rd(1);
         send_cmd(48'h690000000001); want((k < 2) ? 8'h01 : 8'h00); rd(1);
         check("idle_during_init", {31'd0, card_idle}, (k < 2) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic read_word9(input logic [31:0] d);
      send_cmd(48'h510000000901);
      want(8'h00); want(8'hFF); want(8'hFE);
      want(d[31:24]); want(d[23:16]); want(d[15:8]); want(d[7:0]);
      want(8'hFF); want(8'hFF);
      rd(9);
   endtask

   initial begin
      spi_if.SCK  = 1'b1;
      spi_if.SS   = 1'b1;
      spi_if.MOSI = 1'b1;
      rst = 1'b1; pre_we = 1'b0; pre_addr = 8'd0; pre_data = 32'd0;
      repeat (4) @(negedge clk);
      check("rst_miso", {31'd0, spi_if.MISO}, 32'd1);
      check("rst_idle", {31'd0, card_idle}, 32'd1);
      check("rst_index", {26'd0, cmd_index}, 32'd0);
      check("rst_strobe", {31'd0, cmd_strobe}, 32'd0);
      check("rst_memwr", {31'd0, mem_wr}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      spi_if.SS = 1'b0;
      repeat (4) @(negedge clk);

      send_cmd(48'h400000000095); want(8'h01); rd(1);
      check("cmd0_idle", {31'd0, card_idle}, 32'd1);
      check("cmd0_index", {26'd0, cmd_index}, 32'd0);

      send_cmd(48'h400000000001);
`ifdef SD_RESP_CRC_CHECK_EN
      want(8'h09);
`else
      want(8'h01);
`endif
      rd(1);

      send_cmd(48'h48000001AA87);
      want(8'h01); want(8'h00); want(8'h00); want(8'h01); want(8'hAA); rd(5);
      check("cmd8_index", {26'd0, cmd_index}, 32'd8);

      send_cmd(48'h7A0000000001);
      want(8'h01); want(8'hC0); want(8'hFF); want(8'h80); want(8'h00); rd(5);

      init_card();
      check("acmd41_index", {26'd0, cmd_index}, 32'd41);

      @(negedge clk); pre_we = 1'b1; pre_addr = 8'd5; pre_data = 32'hDEADBEEF;
      @(negedge clk); pre_we = 1'b0;
      send_cmd(48'h510000000501);
      want(8'h00); want(8'hFF); want(8'hFE);
      want(8'hDE); want(8'hAD); want(8'hBE); want(8'hEF);
      want(8'hFF); want(8'hFF); want(8'hFF);
      rd(10);

      wr_base = wr_pulses;
      send_cmd(48'h580000000901); want(8'h00); rd(1);
      for (int k = 0; k < 7; k++) want(8'hFF);
      xfer(8'hFE); xfer(8'h12); xfer(8'h34); xfer(8'h56); xfer(8'h78); xfer(8'h00); xfer(8'hFF);
      want(8'h05); want(8'h00); want(8'h00); want(8'hFF); rd(4);
      check("cmd24_memwr_pulses", wr_pulses, wr_base + 1);
      read_word9(32'h12345678);

      send_cmd(48'h580000000901); want(8'h00); rd(1);
      for (int k = 0; k < 3; k++) want(8'hFF);
      xfer(8'hFE); xfer(8'hAA); xfer(8'hBB);
      spi_if.SS = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_miso", {31'd0, spi_if.MISO}, 32'd1);
      spi_if.SS = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_memwr_pulses", wr_pulses, wr_base + 1);
      read_word9(32'h12345678);

      send_cmd(48'h510000012C01); want(8'h40); want(8'hFF); rd(2);
      send_cmd(48'h4D0000000001); want(8'h04); rd(1);
      check("strobe_count", strobes, sent_cmds);

      want(8'hFF); want(8'hFF);
      xfer(8'h7A); xfer(8'h00);
      @(negedge clk); rst = 1'b1;
      #1;
      check("midrst_idle", {31'd0, card_idle}, 32'd1);
      check("midrst_index", {26'd0, cmd_index}, 32'd0);
      check("midrst_miso", {31'd0, spi_if.MISO}, 32'd1);
      check("midrst_memwr", {31'd0, mem_wr}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      spi_if.SS = 1'b1;
      repeat (4) @(negedge clk);
      spi_if.SS = 1'b0;
      repeat (4) @(negedge clk);

      send_cmd(48'h510000000901); want(8'h05); want(8'hFF); rd(2);
      init_card();
      read_word9(32'h12345678);

      spi_byte(8'hFF, rx_dummy);
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
